// File: rtl/cam_pkg.sv
// Shared types, default timing and pixel-format helpers for the camera pattern source.
//   cam_state_e   frame sequencer states
//   cam_bus_t     registered payload of the parallel pixel bus
//   rgb332_to_565 returns {byte0, byte1} of the RGB565 pair for one RGB332 pixel
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } cam_state_e;

  typedef struct packed {
    logic       vsync;
    logic       href;
    logic [7:0] px_data;
  } cam_bus_t;

  localparam int unsigned DEF_AW       = 15;
  localparam int unsigned DEF_H_ACTIVE = 160;
  localparam int unsigned DEF_V_ACTIVE = 120;
  localparam int unsigned DEF_H_BLANK  = 16;
  localparam int unsigned DEF_VS_LINES = 3;
  localparam int unsigned DEF_V_BP     = 2;
  localparam int unsigned DEF_V_FP     = 2;

  // RGB565 with MSB replication; byte0 = R5,G6[5:3], byte1 = G6[2:0],B5.
  function automatic logic [15:0] rgb332_to_565(input logic [7:0] d);
    return {d[7:5], d[7:6], d[4:2], d[4:2], d[1:0], d[1:0], d[1]};
  endfunction

  // Counter width for a count that runs 0..bound-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pattern_tx_if.sv
// Camera-side bus of the pattern source: buffer read port plus OV7670-style pixel bus.
//   mem_rd_addr  buffer read address (source -> buffer)
//   mem_rd_data  RGB332 pixel, one cycle after the address (buffer -> source)
//   vsync/href   frame and line framing
//   px_data      pixel byte
//   frame_done   one-cycle end-of-frame pulse
interface cam_pattern_tx_if #(
  parameter int unsigned AW = 15
);

  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic          frame_done;

  modport master (
    output mem_rd_addr,
    input  mem_rd_data,
    output vsync,
    output href,
    output px_data,
    output frame_done
  );

  modport slave (
    input  mem_rd_addr,
    output mem_rd_data,
    input  vsync,
    input  href,
    input  px_data,
    input  frame_done
  );

endinterface

// File: rtl/cam_line_timer.sv
// Column counter for one line time (2*H_ACTIVE byte cycles + H_BLANK gap).
// Everything except eol_c describes the column of the NEXT cycle, so the top level
// can register its outputs and still have them line up with the state register.
//   pclk, rst        clock, async active-low reset
//   run              counter advances (frame in progress); held at column 0 otherwise
//   eol_c            current cycle is the last column of the line
//   href_nxt_c       next column is inside the active byte window
//   phase_nxt_c      byte phase of next column (0 = byte0, 1 = byte1)
//   fetch_nxt_c      next column is where the following pixel of this line is addressed
//   pre_line_nxt_c   next column is where pixel 0 of the following line is addressed
module cam_line_timer
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK
) (
  input  logic pclk,
  input  logic rst,
  input  logic run,
  output logic eol_c,
  output logic href_nxt_c,
  output logic phase_nxt_c,
  output logic fetch_nxt_c,
  output logic pre_line_nxt_c
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned CW       = cnt_width(LINE_LEN);

  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;

  assign eol_c = (col_q == CW'(LINE_LEN - 1));

  // Wrap at end of line; park at 0 while not running so a new frame starts at column 0.
  always_comb begin
    col_d = '0;
    if (run && !eol_c) begin
      col_d = col_q + CW'(1);
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign href_nxt_c  = (col_d < CW'(2 * H_ACTIVE));
  assign phase_nxt_c = col_d[0];
  // Pixel p+1 is addressed two cycles ahead of its byte0, i.e. at column 2p.
  assign fetch_nxt_c    = !col_d[0] && (col_d < CW'(2 * H_ACTIVE - 2));
  // Pixel 0 of the next line is addressed in the blanking gap, two cycles before wrap.
  assign pre_line_nxt_c = (col_d == CW'(LINE_LEN - 2));

endmodule

// File: rtl/cam_pattern_tx.sv
// OV7670-style camera source: reads an RGB332 frame from a synchronous-read buffer
// and sends it as RGB565 (two bytes per pixel) with vsync/href framing.
//   pclk         pixel clock, rising edge
//   rst          asynchronous reset, active-low
//   en           run enable, looked at only while idle between frames
//   bus          master side of cam_pattern_tx_if (buffer read port + pixel bus)
// Frame: IDLE -> VSYNC -> VBP -> ACTIVE -> VFP -> IDLE, each stage a whole number of
// line times; every stage must be at least one line long.
module cam_pattern_tx
  import cam_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned VS_LINES = DEF_VS_LINES,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_FP     = DEF_V_FP
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  cam_pattern_tx_if.master  bus
);

  localparam int unsigned LINES_MAX = max2(max2(VS_LINES, V_BP), max2(V_ACTIVE, V_FP));
  localparam int unsigned LW        = cnt_width(LINES_MAX);

  cam_state_e    state_q, state_d;
  cam_state_e    stage_next;
  logic          stage_last;
  logic [LW-1:0] line_q, line_d;
  logic [AW-1:0] addr_q, addr_d;
  cam_bus_t      bus_q, bus_d;
  logic          done_q, done_d;
  logic [15:0]   pix565;

  logic eol_c;
  logic href_nxt_c;
  logic phase_nxt_c;
  logic fetch_nxt_c;
  logic pre_line_nxt_c;

  cam_line_timer #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK)
  ) u_line_timer (
    .pclk           (pclk),
    .rst            (rst),
    .run            (state_q != ST_IDLE),
    .eol_c          (eol_c),
    .href_nxt_c     (href_nxt_c),
    .phase_nxt_c    (phase_nxt_c),
    .fetch_nxt_c    (fetch_nxt_c),
    .pre_line_nxt_c (pre_line_nxt_c)
  );

  assign pix565 = rgb332_to_565(bus.mem_rd_data);

  // Next state, line/address counters and next output values.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    addr_d     = addr_q;
    bus_d      = '0;
    done_d     = 1'b0;
    stage_last = 1'b0;
    stage_next = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        stage_next = ST_VSYNC;
      end
      ST_VSYNC: begin
        stage_last = (line_q == LW'(VS_LINES - 1));
        stage_next = ST_VBP;
      end
      ST_VBP: begin
        stage_last = (line_q == LW'(V_BP - 1));
        stage_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        stage_last = (line_q == LW'(V_ACTIVE - 1));
        stage_next = ST_VFP;
      end
      ST_VFP: begin
        stage_last = (line_q == LW'(V_FP - 1));
        stage_next = ST_IDLE;
      end
      default: begin
        stage_last = 1'b1;
        stage_next = ST_IDLE;
      end
    endcase

    if (state_q == ST_IDLE) begin
      if (en) begin
        state_d = ST_VSYNC;
      end
    end else if (eol_c) begin
      if (stage_last) begin
        state_d = stage_next;
        line_d  = '0;
      end else begin
        line_d = line_q + LW'(1);
      end
    end

    // Address 0 is already in place from VSYNC when the first prefetch slot comes
    // round in VBP, so only ACTIVE-line slots advance the address.
    if (state_d == ST_VSYNC) begin
      addr_d = '0;
    end else if (state_d == ST_ACTIVE &&
                 (fetch_nxt_c || (pre_line_nxt_c && line_d != LW'(V_ACTIVE - 1)))) begin
      addr_d = addr_q + AW'(1);
    end

    bus_d.vsync = (state_d == ST_VSYNC);
    bus_d.href  = (state_d == ST_ACTIVE) && href_nxt_c;
    if (bus_d.href) begin
      bus_d.px_data = phase_nxt_c ? pix565[7:0] : pix565[15:8];
    end

    done_d = (state_q == ST_VFP) && (state_d == ST_IDLE);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      addr_q  <= '0;
      bus_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_rd_addr = addr_q;
  assign bus.vsync       = bus_q.vsync;
  assign bus.href        = bus_q.href;
  assign bus.px_data     = bus_q.px_data;
  assign bus.frame_done  = done_q;

endmodule
